// File: rtl/sadd_pkg.sv
// Shared definitions for the serial 2-bit-digit adder controller.
// Holds the digit width, the FSM state encoding and the constants that
// describe the shared LUT full adder: {cout, s} = a + b + c[0], at most 7.
package sadd_pkg;

  localparam int unsigned DIGIT_W    = 2;
  // Adder result width including its carry-out, and its largest result.
  localparam int unsigned FA_RES_W   = DIGIT_W + 1;
  localparam int unsigned FA_MAX_SUM = 7;

  typedef enum logic [1:0] {
    SADD_IDLE = 2'd0,
    SADD_RUN  = 2'd1,
    SADD_DONE = 2'd2
  } sadd_state_e;

endpackage

// File: rtl/serial_digit_add_ctrl.sv
// serial_digit_add_ctrl: WIDTH-bit add/subtract sequenced LSB-first as
// 2-bit digits through an external shared LUT full adder.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand handshake (in_a, in_b, in_cin, in_sub)
//   fa_a, fa_b, fa_c            digit operands and carry to the LUT adder
//   fa_s, fa_cout               adder sum digit / carry-out, same cycle
//   out_valid/out_ready         result handshake (out_sum, out_cout)
//   busy                        operation in progress (RUN or DONE)
//
// Build option: define SADD_SUB_EN to honour in_sub (A - B via A + ~B + 1,
// out_cout = 1 means no borrow). Without it in_sub is ignored.
module serial_digit_add_ctrl
  import sadd_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  input  logic               in_sub,
  output logic [DIGIT_W-1:0] fa_a,
  output logic [DIGIT_W-1:0] fa_b,
  output logic [DIGIT_W-1:0] fa_c,
  input  logic [DIGIT_W-1:0] fa_s,
  input  logic               fa_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic               busy
);

  localparam int unsigned DIGITS = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  sadd_state_e state, state_next;
  logic accept_c, step_c, last_c;

  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next_c;
  logic [WIDTH-1:0] b_load_c;
  logic             carry, carry_load_c;
  logic [CNT_W-1:0] count;

  // Operand B and starting carry as loaded at accept.
`ifdef SADD_SUB_EN
  assign b_load_c     = in_sub ? ~in_b : in_b;
  assign carry_load_c = in_sub ? 1'b1 : in_cin;
`else
  logic sub_unused;
  assign sub_unused   = in_sub;
  assign b_load_c     = in_b;
  assign carry_load_c = in_cin;
`endif

  // Shift registers drain to zero by the end of RUN and carry is cleared on
  // the last digit, so the adder inputs are zero outside RUN with no gating.
  assign fa_a = a_sh[DIGIT_W-1:0];
  assign fa_b = b_sh[DIGIT_W-1:0];
  assign fa_c = {1'b0, carry};

  // New sum digit enters at the top; after DIGITS steps digit 0 is at the bottom.
  assign sum_next_c = (sum_sh >> DIGIT_W) | (WIDTH'(fa_s) << (WIDTH - DIGIT_W));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SADD_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    case (state)
      SADD_IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = SADD_RUN;
        end
      end
      SADD_RUN: begin
        step_c = 1'b1;
        if (count == LAST_DIGIT) begin
          last_c     = 1'b1;
          state_next = SADD_DONE;
        end
      end
      SADD_DONE: begin
        if (out_ready) state_next = SADD_IDLE;
      end
      default: state_next = SADD_IDLE;
    endcase
  end

  // Handshake and status flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next == SADD_IDLE);
      out_valid <= (state_next == SADD_DONE);
      busy      <= (state_next != SADD_IDLE);
    end
  end

  // Operand shifters, carry, digit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (accept_c) begin
      a_sh  <= in_a;
      b_sh  <= b_load_c;
      carry <= carry_load_c;
      count <= '0;
    end else if (step_c) begin
      a_sh   <= a_sh >> DIGIT_W;
      b_sh   <= b_sh >> DIGIT_W;
      sum_sh <= sum_next_c;
      count  <= count + CNT_W'(1);
      carry  <= last_c ? 1'b0 : fa_cout;
      if (last_c) begin
        out_sum  <= sum_next_c;
        out_cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_digit_add_ctrl.sv
// Self-checking bench for serial_digit_add_ctrl (WIDTH=8) with a behavioural
// LUT adder on the fa_* ports. A transaction-level model predicts every
// output each cycle; directed tests add literal expectations.
module tb_serial_digit_add_ctrl;

  localparam int unsigned WIDTH  = 8;
  localparam int          DIGITS = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic [1:0]       fa_a, fa_b, fa_c, fa_s;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural LUT full adder.
  assign {fa_cout, fa_s} = 3'(fa_a) + 3'(fa_b) + 3'(fa_c[0]);

  serial_digit_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_s(fa_s), .fa_cout(fa_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one operation in flight, result due DIGITS cycles after accept.
  bit m_active = 1'b0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int m_a = 0, m_b = 0, m_cin = 0;
  int m_res = 0;

  always @(posedge clk or negedge rst_n) begin
    int b_eff, c_eff;
    if (!rst_n) begin
      m_active <= 1'b0;
      edge_cnt <= 0;
    end else begin
      if (m_active && (edge_cnt - acc_edge) >= DIGITS && out_ready) begin
        m_active <= 1'b0;
      end else if (!m_active && in_valid) begin
        b_eff = int'(in_b);
        c_eff = int'(in_cin);
`ifdef SADD_SUB_EN
        if (in_sub) begin
          b_eff = int'(~in_b);
          c_eff = 1;
        end
`endif
        m_active <= 1'b1;
        acc_edge <= edge_cnt + 1;
        m_a      <= int'(in_a);
        m_b      <= b_eff;
        m_cin    <= c_eff;
        m_res    <= int'(in_a) + b_eff + c_eff;
      end
      edge_cnt <= edge_cnt + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int k, mask, cy;
    bit dv;
    if (rst_n) begin
      k  = edge_cnt - acc_edge;
      dv = m_active && (k >= DIGITS);
      chk("busy", 32'(busy), 32'(m_active));
      chk("in_ready", 32'(in_ready), 32'(!m_active));
      chk("out_valid", 32'(out_valid), 32'(dv));
      if (m_active && k < DIGITS) begin
        mask = (1 << (2 * k)) - 1;
        cy   = ((m_a & mask) + (m_b & mask) + m_cin) >> (2 * k);
        chk("fa_a", 32'(fa_a), 32'((m_a >> (2 * k)) & 3));
        chk("fa_b", 32'(fa_b), 32'((m_b >> (2 * k)) & 3));
        chk("fa_c", 32'(fa_c), 32'(cy & 1));
      end else begin
        chk("fa_a_idle", 32'(fa_a), 32'd0);
        chk("fa_b_idle", 32'(fa_b), 32'd0);
        chk("fa_c_idle", 32'(fa_c), 32'd0);
      end
      if (dv) begin
        chk("out_sum", 32'(out_sum), 32'(m_res & 8'hFF));
        chk("out_cout", 32'(out_cout), 32'((m_res >> 8) & 1));
      end
    end
  end

  // One operation starting at a negedge; ends at the negedge after the
  // output handshake so a following call can present operands back-to-back.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] es, input logic ec,
                        input int hold, input bit trace);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 8'hXX; in_b = 8'hXX; in_cin = 1'bx;
    n = 0;
    if (trace) begin
      for (int k = 0; k < DIGITS; k++) begin
        chk("trace_fa_a", 32'(fa_a), 32'(k));
        chk("trace_fa_b", 32'(fa_b), 32'(3 - k));
        chk("trace_fa_c", 32'(fa_c), 32'd0);
        @(negedge clk); n++;
      end
    end
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'(DIGITS));
    chk("lit_sum", 32'(out_sum), 32'(es));
    chk("lit_cout", 32'(out_cout), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(out_sum), 32'(es));
      chk("hold_cout", 32'(out_cout), 32'(ec));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    run_op(8'hE4, 8'h1B, 1'b0, 1'b0, 8'hFF, 1'b0, 0, 1'b1);
    // Backpressure, then an operand presented right after the handshake.
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 3, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 0, 1'b0);

    // Reset two digits into an operation.
    in_a = 8'hAB; in_b = 8'hCD; in_cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 0, 1'b0);

`ifdef SADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 0, 1'b0);
`else
    run_op(8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0, 0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_digit_add_ctrl.md
Name: serial_digit_add_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add (or subtract) by streaming 2-bit digits, LSB-first, through one shared 2-bit SRAM-LUT full adder (fulladder_sram, instantiated by the parent).
- Accepts one operand pair on a valid/ready handshake, drives one digit per clock, collects sum digits and ripple carry, returns the result on a valid/ready handshake.
- Sits between the operand source and the LUT adder; owns carry state and digit count.

Parameters:
- WIDTH, 8, operand/result width in bits; even, >= 2.
- DIGITS, WIDTH/2, derived localparam; digit cycles per operation.

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in, add mode only.
- in_sub  input  1  subtract request; honoured only with SADD_SUB_EN.
- fa_a  output  2  digit of A to adder.
- fa_b  output  2  digit of B to adder.
- fa_c  output  2  carry to adder: {1'b0, carry}.
- fa_s  input  2  adder sum digit; combinational, same cycle.
- fa_cout  input  1  adder carry-out, same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Adder contract: {fa_cout, fa_s} = fa_a + fa_b + fa_c[0]. The maximum is 7, so no overflow occurs.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values:
  - out_valid=0, out_sum=0, out_cout=0, busy=0, fa_a/fa_b/fa_c=0.
  - in_ready=1, because in_ready = (state==IDLE).
- IDLE:
  - On in_valid && in_ready, load the A and B shift registers and set carry = in_cin, count = 0, then go to RUN.
  - With no in_valid, hold.
- RUN, one digit per cycle:
  - Drive fa_a=a_sh[1:0], fa_b=b_sh[1:0], fa_c={1'b0,carry}.
  - At the clock edge: shift fa_s into result bits [2*count+1:2*count], set carry<=fa_cout, shift A and B right by 2, count++.
  - After digit DIGITS-1, register out_cout<=fa_cout and go to DONE.
- DONE:
  - out_valid=1. out_sum and out_cout are held stable while out_ready=0.
  - On out_valid && out_ready, go to IDLE.
  - The result registers keep their last value; only out_valid drops.
- Latency: operands accepted at edge T; out_valid is high in the cycle after edge T+DIGITS (e.g. 4 RUN cycles, then DONE, for WIDTH=8).
- No overlap: in_ready=0 throughout RUN and DONE. A new accept is possible in the cycle after the output handshake.
- fa_* outputs are 0 in IDLE and DONE.
- Asynchronous reset at any time, including mid-RUN, aborts the operation: partial result and carry are discarded, state goes to IDLE, and all outputs take their reset values.
- in_a, in_b and in_cin are don't-care except at the accept edge.

Optional Feature:
- SADD_SUB_EN defined:
  - At accept, if in_sub=1: B register loads ~in_b, carry loads 1, in_cin is ignored.
  - Result is A-B. out_cout=1 means no borrow.
- SADD_SUB_EN undefined:
  - in_sub is ignored; the block always adds.
  - The subtract mux is removed from the RTL.

Decomposition:
- Shared package/include sadd_pkg holds:
  - DIGIT_W=2.
  - State encodings SADD_IDLE=2'd0, SADD_RUN=2'd1, SADD_DONE=2'd2.
  - The adder contract constants.
- No internal sub-module: FSM, shift registers and counter stay in one module. The LUT adder remains a separate instance in the parent.
- The bench instantiates fulladder_sram, or a behavioural model of it, on the fa_* ports.

Test Plan:
- WIDTH=8, in_a=8'h5A, in_b=8'h3C, in_cin=0 -> out_sum=8'h96, out_cout=0; out_valid is high in the 5th cycle after the accept edge.
- in_a=8'hFF, in_b=8'h01, in_cin=0 -> carry ripples through all 4 digits; out_sum=8'h00, out_cout=1.
- Per-digit trace, in_a=8'hE4, in_b=8'h1B:
  - fa_a must be 0,1,2,3 and fa_b must be 3,2,1,0 on successive RUN cycles, with fa_c=0 every cycle.
  - Result: out_sum=8'hFF, out_cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_sum, out_cout and out_valid stay stable and in_ready=0. Raise out_ready -> in_ready=1 next cycle and a back-to-back operand is accepted.
- Reset mid-operation: assert rst_n=0 after 2 RUN digits -> out_valid=0, busy=0, fa_*=0, in_ready=1 immediately. Then 8'h01+8'h02 -> 8'h03, out_cout=0.
- SADD_SUB_EN defined:
  - 8'h10-8'h01 (in_sub=1) -> 8'h0F, out_cout=1.
  - 8'h01-8'h02 -> 8'hFF, out_cout=0.
- SADD_SUB_EN undefined: 8'h01 with in_b=8'h02, in_sub=1 -> 8'h03.
